seq_frame_tx: RTL and testbench

- Serial frame transmitter: the sending end of the serial sync-detect link.
- On a start handshake it drives a fixed sync pattern (default 00010, the pattern our sequence detector recognises), then a parallel payload word MSB-first, then an idle gap, on a single-bit line X.
- Sits between a control/stimulus source and any serial consumer. Idle line level is 1, so the detector stays in its reset state between frames.

---
 rtl/seq_frame_tx.sv | 125 ++++++++++++
 tb/tb_seq_frame_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, then the payload MSB-first, then an idle gap, on line X.
// Every output comes straight from a flop, so no input reaches an output combinationally.
module seq_frame_tx #(
  parameter int                    DATA_W     = 8,
  parameter int                    SYNC_LEN   = 5,
  parameter logic [SYNC_LEN-1:0]   SYNC_PAT   = 5'b00010,
  parameter int                    GAP_CYCLES = 2,
  parameter logic                  IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              X,
  output logic              done,
  output logic [2:0]        state
);

  localparam int CNT_W = 5;
  localparam logic [7:0] SYNC_EXT = 8'(SYNC_PAT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_SYNC = 3'b001,
    ST_DATA = 3'b010,
    ST_GAP  = 3'b011
  } state_t;

  state_t             state_q, state_d;
  logic               x_q, x_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= IDLE_LEVEL;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt_q holds the number of bits still to send after the current one
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        x_d     = IDLE_LEVEL;
        ready_d = 1'b1;
        if (start && ready_q) begin
          shift_d = data_in;
          state_d = ST_SYNC;
          x_d     = SYNC_PAT[SYNC_LEN-1];
          ready_d = 1'b0;
          cnt_d   = CNT_W'(SYNC_LEN - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (cnt_q == 5'd0) begin
          x_d     = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = ST_DATA;
        end else begin
          x_d   = SYNC_EXT[cnt_q[2:0] - 3'd1];
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 5'd0) begin
          x_d     = IDLE_LEVEL;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else begin
          x_d     = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - 5'd1;
        end
      end
      ST_GAP: begin
        x_d = IDLE_LEVEL;
        if (cnt_q == 5'd0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = IDLE_LEVEL;
        ready_d = 1'b1;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready = ready_q;
  assign X     = x_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: a frame-level model queues the expected per-cycle line/status,
// and an independent monitor pops and compares on every falling edge.
module tb_seq_frame_tx;

  localparam int         DW = 8;
  localparam int         SL = 5;
  localparam int         GC = 2;
  localparam logic [4:0] SP = 5'b00010;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] data_in;
  logic          ready;
  logic          X;
  logic          done;
  logic [2:0]    state;

  always #5 clk = ~clk;

  seq_frame_tx #(
    .DATA_W(DW), .SYNC_LEN(SL), .SYNC_PAT(SP), .GAP_CYCLES(GC), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .ready(ready), .X(X), .done(done), .state(state)
  );

  typedef struct packed {
    logic       x;
    logic       rdy;
    logic       dn;
    logic [2:0] st;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  logic [4:0] hist = 5'b11111;
  int         det_cnt = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic x, input logic r, input logic d, input logic [2:0] s);
    exp_t e;
    e.x = x; e.rdy = r; e.dn = d; e.st = s;
    return e;
  endfunction

  // A frame as seen on the line: sync bits, payload MSB-first, gap, then the done/ready cycle
  task automatic push_frame(input logic [DW-1:0] d);
    for (int i = SL - 1; i >= 0; i--) q.push_back(mk(SP[i], 1'b0, 1'b0, 3'd1));
    for (int i = DW - 1; i >= 0; i--) q.push_back(mk(d[i], 1'b0, 1'b0, 3'd2));
    for (int i = 0; i < GC; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 3'd3));
    q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd0));
  endtask

  // Only the current cycle left in the queue means the transmitter is ready this cycle
  task automatic step(input logic s, input logic [DW-1:0] d);
    start   = s;
    data_in = d;
    if (q.size() == 1) begin
      if (s) push_frame(d);
      else   q.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_X"}, 8'(X), 8'h01);
    chk({tag, "_ready"}, 8'(ready), 8'h01);
    chk({tag, "_done"}, 8'(done), 8'h00);
    chk({tag, "_state"}, 8'(state), 8'h00);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    #2;
    check_reset_vals("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    q.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0));
    hist   = 5'b11111;
    mon_en = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("X", 8'(X), 8'(e.x));
          chk("ready", 8'(ready), 8'(e.rdy));
          chk("done", 8'(done), 8'(e.dn));
          chk("state", 8'(state), 8'(e.st));
        end
      end
      hist = {hist[3:0], X};
      if (hist == 5'b00010) det_cnt++;
    end
  end

  initial begin
    int d0;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    #3;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0));
    mon_en = 1'b1;
    repeat (3) step(1'b0, 8'h00);

    // A5 frame with a stray start at t0+4 that must be ignored
    step(1'b1, 8'hA5);
    repeat (3) step(1'b0, 8'h00);
    step(1'b1, 8'h00);
    repeat (16) step(1'b0, 8'h00);

    // start held high: FF accepted, then 0F on the next ready edge
    step(1'b1, 8'hFF);
    repeat (16) step(1'b1, 8'h0F);
    repeat (20) step(1'b0, 8'h00);

    // Loopback sync detection: exactly one hit per FF frame
    d0 = det_cnt;
    step(1'b1, 8'hFF);
    repeat (20) step(1'b0, 8'h00);
    chk("detect_once", 8'(det_cnt - d0), 8'h01);

    // Reset in the middle of the payload, then a clean frame
    step(1'b1, 8'h3C);
    repeat (8) step(1'b0, 8'h00);
    do_reset();
    repeat (3) step(1'b0, 8'h00);
    step(1'b1, 8'h96);
    repeat (18) step(1'b0, 8'h00);

    repeat (800) step($urandom_range(0, 3) == 0, 8'($urandom));

    for (int i = 0; i < 40; i++) begin
      if (q.size() > 1) step(1'b0, 8'h00);
    end
    step(1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
